// File: rtl/tz80_pkg.sv
// tz80_pkg: shared FSM encoding, error data and default parameters for the memory responder.
package tz80_pkg;
  typedef enum logic [1:0] {DECODE, EXT_WAIT, DONE} state_t;
  localparam logic [7:0] ERR_DATA = 8'hFF;
  localparam int INT_AW_DEF = 12;
  localparam int TIMEOUT_DEF = 255;
endpackage

// File: rtl/tz80_ram.sv
// tz80_ram: single-port 2^AW x 8 RAM, synchronous write and one-cycle registered read.
module tz80_ram #(
  parameter int AW = 12
) (
  input  logic          clock,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem [2**AW];
  always_ff @(posedge clock) begin
    if (en && we) mem[addr] <= wdata;
    if (en && !we) rdata <= mem[addr];
  end
endmodule

// File: rtl/tz80_mem_responder.sv
// tz80_mem_responder: CPU memory responder with internal RAM and a timed external request port.
module tz80_mem_responder
  import tz80_pkg::*;
#(
  parameter int INT_AW  = INT_AW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [7:0]  o_data,
  input  logic        we,
  output logic [7:0]  i_data,
  output logic        locked,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_wdata,
  output logic        ext_we,
  output logic        ext_req,
  input  logic [7:0]  ext_rdata,
  input  logic        ext_ack,
  output logic        bus_error
);
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  i_data_q, i_data_d;
  logic [15:0] ext_addr_q, ext_addr_d;
  logic [7:0]  ext_wdata_q, ext_wdata_d;
  logic        ext_we_q, ext_we_d;
  logic        ext_req_q, ext_req_d;
  logic        bus_error_q, bus_error_d;
  logic        rd_q, rd_d;
  logic        ram_en;
  logic [7:0]  ram_rdata;
  logic        int_hit;
  assign int_hit = 32'(address) < (32'd1 << INT_AW);
  tz80_ram #(.AW(INT_AW)) u_ram (
    .clock (clock),
    .en    (ram_en),
    .we    (we),
    .addr  (address[INT_AW-1:0]),
    .wdata (o_data),
    .rdata (ram_rdata)
  );
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    i_data_d    = i_data_q;
    ext_addr_d  = ext_addr_q;
    ext_wdata_d = ext_wdata_q;
    ext_we_d    = ext_we_q;
    ext_req_d   = ext_req_q;
    bus_error_d = bus_error_q;
    rd_d        = rd_q;
    ram_en      = 1'b0;
    case (state_q)
      DECODE: begin
        cnt_d = '0;
        if (int_hit) begin
          ram_en  = 1'b1;
          rd_d    = !we;
          state_d = DONE;
        end else begin
          ext_req_d   = 1'b1;
          ext_addr_d  = address;
          ext_wdata_d = o_data;
          ext_we_d    = we;
          rd_d        = 1'b0;
          state_d     = EXT_WAIT;
        end
      end
      EXT_WAIT: begin
        // ack takes priority over an expiring wait counter
        if (ext_ack) begin
          i_data_d  = ext_we_q ? i_data_q : ext_rdata;
          ext_req_d = 1'b0;
          state_d   = DONE;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          i_data_d    = ERR_DATA;
          ext_req_d   = 1'b0;
          bus_error_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        i_data_d = rd_q ? ram_rdata : i_data_q;
        state_d  = DECODE;
      end
      default: state_d = DECODE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= DECODE;
      cnt_q       <= '0;
      i_data_q    <= '0;
      ext_addr_q  <= '0;
      ext_wdata_q <= '0;
      ext_we_q    <= 1'b0;
      ext_req_q   <= 1'b0;
      bus_error_q <= 1'b0;
      rd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      i_data_q    <= i_data_d;
      ext_addr_q  <= ext_addr_d;
      ext_wdata_q <= ext_wdata_d;
      ext_we_q    <= ext_we_d;
      ext_req_q   <= ext_req_d;
      bus_error_q <= bus_error_d;
      rd_q        <= rd_d;
    end
  end
  // internal read data comes straight from the RAM register during DONE
  assign i_data    = (state_q == DONE && rd_q) ? ram_rdata : i_data_q;
  assign locked    = state_q == DONE;
  assign ext_addr  = ext_addr_q;
  assign ext_wdata = ext_wdata_q;
  assign ext_we    = ext_we_q;
  assign ext_req   = ext_req_q;
  assign bus_error = bus_error_q;
endmodule
